// File: rtl/risc16_pkg.sv
// ---------------------------------------------------------------------------
// risc16_pkg
// Shared definitions for the RiSC-16 data-memory path.
//   WORD_W       : data word width
//   mem_state_t  : responder FSM states
//   SW / LW      : opcodes used by the core-side adapter
// ---------------------------------------------------------------------------
package risc16_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } mem_state_t;

  localparam logic [2:0] SW = 3'b100;
  localparam logic [2:0] LW = 3'b101;

endpackage

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Synchronous single-port RAM, DEPTH x WORD_W, registered read.
// Contents are never reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (old contents on a same-address write)
// ---------------------------------------------------------------------------
module mem_array
  import risc16_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// ---------------------------------------------------------------------------
// data_mem_resp
// Memory-side responder for RiSC-16 loads/stores. One request in flight;
// fixed WAIT_CYCLES wait states, then a one-cycle array access, then a
// response held until taken.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake
//   req_we                : 1 = store, 0 = load
//   req_addr, req_wdata   : word address, store data
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : load data (0 for stores and errors)
//   rsp_err               : address out of range
// ---------------------------------------------------------------------------
module data_mem_resp
  import risc16_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              in_range;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  // Full-width compare: addresses >= DEPTH are errors, never aliased.
  assign in_range = (32'(addr_q) < 32'(DEPTH));

  // The RAM read is registered, so the address must be on the RAM one edge
  // before ACCESS. In IDLE the live request address is used so that the
  // zero-wait case (accept edge goes straight to ACCESS) still reads in time.
  assign ram_addr = (state_q == IDLE) ? req_addr[AW-1:0] : addr_q[AW-1:0];
  assign ram_we   = (state_q == ACCESS) && we_q && in_range;

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        // req_ready_q is 0 for the first cycle after reset, blocking accepts
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = !in_range;
        rsp_rdata_d = (in_range && !we_q) ? ram_rdata : '0;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_data_mem_resp
// Scoreboard bench: the driver pushes the hand-computed response for each
// accepted request; a negedge monitor pops and compares whenever the DUT
// presents a response, and re-checks it every cycle it is held.
// A second instance with WAIT_CYCLES=0 checks back-to-back timing.
// ---------------------------------------------------------------------------
module tb_data_mem_resp;

  localparam int WC = 2;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          acc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n, rst0_n;
  logic        req_valid, req_we, rsp_ready;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;

  logic        r0_req_valid, r0_req_we, r0_rsp_ready;
  logic [15:0] r0_req_addr, r0_req_wdata;
  logic        r0_req_ready, r0_rsp_valid, r0_rsp_err;
  logic [15:0] r0_rsp_rdata;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  sb_t sb[$];
  sb_t cur;
  bit  in_resp  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0_n),
    .req_valid(r0_req_valid), .req_ready(r0_req_ready), .req_we(r0_req_we),
    .req_addr(r0_req_addr), .req_wdata(r0_req_wdata),
    .rsp_valid(r0_rsp_valid), .rsp_ready(r0_rsp_ready),
    .rsp_rdata(r0_rsp_rdata), .rsp_err(r0_rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop on the first cycle of a response, then verify it stays put.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 1'b0;
    end else if (rsp_valid) begin
      if (!in_resp) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b, required no response",
                   rsp_rdata, rsp_err);
        end else begin
          cur = sb.pop_front();
          $display("rsp: rdata=0x%04h err=%0b latency=%0d", rsp_rdata, rsp_err, cyc - cur.acc);
          chk("rsp_latency", 32'(cyc - cur.acc), 32'(WC + 1));
        end
      end
      chk("rsp_rdata", 32'(rsp_rdata), 32'(cur.rdata));
      chk("rsp_err", 32'(rsp_err), 32'(cur.err));
      chk("req_ready_while_rsp", 32'(req_ready), 32'd0);
      in_resp = !rsp_ready;
    end
  end

  // Issue one request; push its expected response; optionally wait for it.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rd, input logic exp_err, input bit wait_rsp);
    int  n = 0;
    sb_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    $display("req: we=%0b addr=0x%04h wdata=0x%04h", we, addr, wdata);
    e.rdata = exp_rd; e.err = exp_err; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (wait_rsp) begin
      n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) chk("rsp_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_rsp_valid();
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; rst0_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_addr = '0; r0_req_wdata = '0;
    r0_rsp_ready = 1'b1;

    // Reset then idle
    #2 rst_n = 1'b0; rst0_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst0_n = 1'b1;
    #1 chk("rel_req_ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_req_ready_after_edge", 32'(req_ready), 32'd1);
    chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);

    // Store then load
    do_req(1'b1, 16'h0000, 16'h5A5A, 16'h0000, 1'b0, 1'b1);
    do_req(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b1);
    do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    do_req(1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0, 1'b1);

    // Range boundaries and no aliasing
    do_req(1'b1, 16'h0400, 16'h1234, 16'h0000, 1'b1, 1'b1);
    do_req(1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0, 1'b1);
    do_req(1'b1, 16'h03FF, 16'h0F0F, 16'h0000, 1'b0, 1'b1);
    do_req(1'b0, 16'h03FF, 16'h0000, 16'h0F0F, 1'b0, 1'b1);
    do_req(1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1'b1);
    do_req(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1);

    // Backpressure with a competing store that must be ignored
    rsp_ready = 1'b0;
    do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    wait_rsp_valid();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'h0000;
    repeat (10) @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("bp_release_req_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);

    // Reset mid-WAIT drops the pending store
    do_req(1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0, 1'b1);
    do_req(1'b1, 16'h0020, 16'hAAAA, 16'h0000, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midwait_req_ready", 32'(req_ready), 32'd0);
    chk("midwait_rsp_valid", 32'(rsp_valid), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b1);

    // Reset while a response is held clears outputs without a clock edge
    rsp_ready = 1'b0;
    do_req(1'b0, 16'h03FF, 16'h0000, 16'h0F0F, 1'b0, 1'b0);
    wait_rsp_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("resp_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("resp_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("resp_rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("resp_rst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0, 1'b1);

    // Zero wait states, request held valid: accept / idle / response repeating
    @(negedge clk);
    r0_req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int k;
      k = i / 3;
      if (i % 3 == 0) begin
        chk("w0_req_ready_accept", 32'(r0_req_ready), 32'd1);
        chk("w0_rsp_valid_accept", 32'(r0_rsp_valid), 32'd0);
        r0_req_we    = (k < 3);
        r0_req_addr  = (k < 3) ? 16'(k + 1) : 16'h0002;
        r0_req_wdata = 16'(16'h1001 + k);
        $display("w0 req: we=%0b addr=0x%04h wdata=0x%04h", r0_req_we, r0_req_addr, r0_req_wdata);
      end else if (i % 3 == 1) begin
        chk("w0_req_ready_access", 32'(r0_req_ready), 32'd0);
        chk("w0_rsp_valid_access", 32'(r0_rsp_valid), 32'd0);
      end else begin
        $display("w0 rsp: valid=%0b rdata=0x%04h err=%0b", r0_rsp_valid, r0_rsp_rdata, r0_rsp_err);
        chk("w0_req_ready_resp", 32'(r0_req_ready), 32'd0);
        chk("w0_rsp_valid_resp", 32'(r0_rsp_valid), 32'd1);
        chk("w0_rsp_rdata", 32'(r0_rsp_rdata), (k < 3) ? 32'd0 : 32'h1002);
        chk("w0_rsp_err", 32'(r0_rsp_err), 32'd0);
      end
      @(negedge clk);
    end
    r0_req_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
